// File: rtl/i2s_pkg.sv
// Constants and types shared by the I2S transmitter and receiver.
package i2s_pkg;

    localparam int unsigned MAX_PDATA_WIDTH = 32;
    // Wide enough to count one full frame at the largest channel width.
    localparam int unsigned P_CNT_W = $clog2(2 * MAX_PDATA_WIDTH);

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_state_e;

    function automatic int unsigned frame_len(input int unsigned pdata_width);
        return 2 * pdata_width;
    endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// I2S bit-clock divider: toggles sclk every SCLK_DIV cycles and strobes the
// cycle in which sclk is about to fall.
module i2s_sclk_gen #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic sclk_o,
    output logic fall_o
);

    localparam int unsigned CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    always_comb begin
        wrap   = (cnt_q == CW'(SCLK_DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        sclk_d = wrap ? ~sclk_q : sclk_q;
        fall_o = wrap & sclk_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-frame holding register feeding a frame shift register,
// serialised MSB first with the standard one-bit delay after lrck changes.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned PDATA_WIDTH = 32,
    parameter int unsigned SCLK_DIV    = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [PDATA_WIDTH-1:0] pldata_in,
    input  logic [PDATA_WIDTH-1:0] prdata_in,
    input  logic                   pvalid_in,
    output logic                   pready_out,
    output logic                   sclk_out,
    output logic                   lrck_out,
    output logic                   sdata_out,
    output logic                   underrun_out
);

    localparam int unsigned          FRAME  = frame_len(PDATA_WIDTH);
    localparam logic [P_CNT_W-1:0]   P_LAST = P_CNT_W'(FRAME - 1);
    localparam logic [P_CNT_W-1:0]   P_HALF = P_CNT_W'(PDATA_WIDTH);

    hold_state_e        state_q, state_d;
    logic [FRAME-1:0]   hold_q, hold_d;
    logic [FRAME-1:0]   shift_q, shift_d;
    logic [P_CNT_W-1:0] p_q, p_d;
    logic               lrck_q, lrck_d;
    logic               sdata_q, sdata_d;
    logic               under_q, under_d;
    logic               fall;
    logic               capture;
    logic               frame_start;

    i2s_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .sclk_o (sclk_out),
        .fall_o (fall)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        p_d         = p_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        under_d     = 1'b0;
        capture     = pvalid_in && (state_q == HOLD_EMPTY);
        frame_start = fall && (p_q == P_LAST);

        // The bit leaving the shift MSB at p=0 is the previous frame's right LSB.
        if (fall) begin
            p_d     = frame_start ? '0 : p_q + 1'b1;
            lrck_d  = (p_d >= P_HALF);
            sdata_d = shift_q[FRAME-1];
            shift_d = {shift_q[FRAME-2:0], 1'b0};
        end

        if (frame_start) begin
            if (state_q == HOLD_FULL) begin
                shift_d = hold_q;
                state_d = HOLD_EMPTY;
            end else begin
                shift_d = '0;
                under_d = 1'b1;
            end
        end

        // A capture in the transfer cycle only sees an empty holder, so it waits a frame.
        if (capture) begin
            hold_d  = {pldata_in, prdata_in};
            state_d = HOLD_FULL;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= HOLD_EMPTY;
            hold_q  <= '0;
            shift_q <= '0;
            p_q     <= P_LAST;
            lrck_q  <= 1'b1;
            sdata_q <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            p_q     <= p_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
            under_q <= under_d;
        end
    end

    assign pready_out   = (state_q == HOLD_EMPTY);
    assign lrck_out     = lrck_q;
    assign sdata_out    = sdata_q;
    assign underrun_out = under_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx against a timeline-based behavioural model.
module tb_i2s_tx;

    localparam int W   = 16;
    localparam int DIV = 2;
    localparam int FL  = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          pvalid;
    logic [W-1:0]  pl, pr;
    logic          pready, sclk, lrck, sdata, under;

    always #5 clk = ~clk;

    i2s_tx #(
        .PDATA_WIDTH (W),
        .SCLK_DIV    (DIV)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .pldata_in    (pl),
        .prdata_in    (pr),
        .pvalid_in    (pvalid),
        .pready_out   (pready),
        .sclk_out     (sclk),
        .lrck_out     (lrck),
        .sdata_out    (sdata),
        .underrun_out (under)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: everything derives from n = clk edges since reset release.
    int unsigned   n = 0;
    bit            pend_v = 0;
    logic [31:0]   pend = '0;
    logic [31:0]   cur = '0;
    logic [31:0]   last_frame = '0;
    bit            m_under = 0, m_sdata = 0, m_fall = 0, m_cap = 0;
    int            m_p = FL - 1;

    // Loopback deserialiser of the observed sdata.
    logic [31:0]   rx_acc = '0;
    logic [31:0]   last_rx = '0;
    int            rx_cnt = 0;

    function automatic int p_of(input int unsigned nn);
        return ((nn / (2 * DIV)) + FL - 1) % FL;
    endfunction

    task automatic model_edge(input bit r, input bit v, input logic [W-1:0] l, input logic [W-1:0] rr);
        bit cap;
        m_fall = 0;
        m_cap  = 0;
        if (r) begin
            n = 0; pend_v = 0; pend = '0; cur = '0;
            m_under = 0; m_sdata = 0;
        end else begin
            cap = v && !pend_v;
            n++;
            m_under = 0;
            if (n % (2 * DIV) == 0) begin
                m_fall = 1;
                m_p = p_of(n);
                if (m_p == 0) begin
                    last_frame = cur;
                    m_sdata = cur[0];
                    if (pend_v) begin
                        cur = pend;
                        pend_v = 0;
                    end else begin
                        cur = '0;
                        m_under = 1;
                    end
                end else begin
                    m_sdata = cur[32 - m_p];
                end
            end
            if (cap) begin
                pend = {l, rr};
                pend_v = 1;
                m_cap = 1;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [W-1:0] l, input logic [W-1:0] rr);
        rst = r; pvalid = v; pl = l; pr = rr;
        @(posedge clk);
        model_edge(r, v, l, rr);
        #1;
        check_eq("sclk",     32'(sclk),   32'((n / DIV) % 2));
        check_eq("lrck",     32'(lrck),   32'(p_of(n) >= W));
        check_eq("sdata",    32'(sdata),  32'(m_sdata));
        check_eq("pready",   32'(pready), 32'(!pend_v));
        check_eq("underrun", 32'(under),  32'(m_under));
        if (r) begin
            rx_acc = '0;
            rx_cnt = 0;
        end else if (m_fall) begin
            if (m_p == 0) begin
                if (rx_cnt == FL - 1) begin
                    last_rx = {rx_acc[30:0], sdata};
                    check_eq("rxword", last_rx, last_frame);
                end
                rx_acc = '0;
                rx_cnt = 0;
            end else begin
                rx_acc = {rx_acc[30:0], sdata};
                rx_cnt++;
            end
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, '0, '0);
    endtask

    int unsigned inc;
    int unsigned under_cnt;
    int          guard;

    initial begin
        rst = 1'b1; pvalid = 1'b0; pl = '0; pr = '0;

        // Reset, then a directed frame captured before the first p=0.
        for (int i = 0; i < 4; i++) step(1, 0, '0, '0);
        check_eq("rst_sclk",  32'(sclk),   32'd0);
        check_eq("rst_lrck",  32'(lrck),   32'd1);
        check_eq("rst_ready", 32'(pready), 32'd1);
        step(0, 1, 16'hA5C3, 16'h0F01);
        idle(139);
        check_eq("dir_frame", last_rx, 32'hA5C30F01);

        // Idle: zeros and an underrun every frame.
        idle(300);

        // Random sparse traffic; pvalid while full must not overwrite.
        for (int i = 0; i < 3000; i++)
            step(0, ($urandom_range(0, 7) == 0), W'($urandom), W'($urandom));

        // Continuous pvalid with an incrementing pattern.
        inc = 1;
        under_cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            step(0, 1, W'(inc), W'(~inc));
            if (m_cap) inc++;
            if (i >= 260 && under) under_cnt++;
        end
        check_eq("cont_no_underrun", under_cnt, 32'd0);

        // pvalid exactly in the p=0 transfer cycle.
        idle(300);
        guard = 0;
        while (!(((n + 1) % (2 * DIV) == 0) && (p_of(n + 1) == 0)) && guard < 200) begin
            step(0, 0, '0, '0);
            guard++;
        end
        check_eq("coinc_guard", 32'(guard < 200), 32'd1);
        step(0, 1, 16'h1234, 16'h5678);
        check_eq("coinc_under", 32'(under), 32'd1);
        check_eq("coinc_ready", 32'(pready), 32'd0);
        idle(260);
        check_eq("coinc_frame", last_rx, 32'h12345678);

        // Reset at p=20 with held data: the held frame is discarded.
        guard = 0;
        while (p_of(n) != 5 && guard < 200) begin
            step(0, 0, '0, '0);
            guard++;
        end
        step(0, 1, 16'hDEAD, 16'hBEEF);
        guard = 0;
        while (p_of(n) != 20 && guard < 200) begin
            step(0, 0, '0, '0);
            guard++;
        end
        check_eq("p20_guard", 32'(guard < 200), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 0, '0, '0);
        check_eq("midrst_lrck",  32'(lrck),   32'd1);
        check_eq("midrst_sdata", 32'(sdata),  32'd0);
        check_eq("midrst_under", 32'(under),  32'd0);
        idle(400);
        check_eq("midrst_discard", last_rx, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
